// File: rtl/period_link_pkg.sv
// Shared types and constants for the period-capture read/framing path.
package period_link_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, REQ, WAIT, HI, LO, CKSUM} state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [15:0] SAT_WORD          = 16'hFFFF;

  // Bytes on the wire per frame: sync + seq + 2 per word + checksum.
  function automatic int frame_len(input int words);
    return 2 + 2 * words + 1;
  endfunction

endpackage

// File: rtl/period_frame_reader_if.sv
// FIFO read port plus framed byte stream between reader and host-link transmitter.
interface period_frame_reader_if;
  logic        fifo_empty;
  logic [15:0] fifo_q;
  logic        fifo_rdreq;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (input fifo_empty, fifo_q, byte_ready,
                  output fifo_rdreq, byte_out, byte_valid);
  modport slave  (output fifo_empty, fifo_q, byte_ready,
                  input fifo_rdreq, byte_out, byte_valid);
endinterface

// File: rtl/period_frame_reader.sv
// Pops 16-bit period words from the capture FIFO and emits framed bytes:
// sync, seq, data (MSB first), 8-bit checksum over seq and data.
module period_frame_reader
  import period_link_pkg::*;
#(
  parameter int         WORDS_PER_FRAME = 4,
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  period_frame_reader_if.master  bus,
  output logic                   frame_busy,
  output logic [7:0]             sat_count
);

  state_t      state, state_n;
  logic [7:0]  seq, checksum, cks_n, idx, byte_n;
  logic [15:0] word, word_n;
  logic        xfer, last_word;

  assign xfer       = bus.byte_valid && bus.byte_ready;
  assign last_word  = (idx == 8'(WORDS_PER_FRAME - 1));
  assign frame_busy = (state != IDLE);

  always_comb begin
    state_n        = state;
    cks_n          = checksum;
    word_n         = word;
    bus.fifo_rdreq = 1'b0;
    case (state)
      IDLE:  if (!bus.fifo_empty) state_n = SYNC;
      SYNC:  if (xfer) state_n = SEQ;
      SEQ: begin
        cks_n = seq;
        if (xfer) state_n = REQ;
      end
      REQ: if (!bus.fifo_empty) begin
        bus.fifo_rdreq = 1'b1;
        state_n        = WAIT;
      end
      WAIT: begin
        word_n  = bus.fifo_q;
        state_n = HI;
      end
      HI: if (xfer) begin
        cks_n   = checksum + word[15:8];
        state_n = LO;
      end
      LO: if (xfer) begin
        cks_n   = checksum + word[7:0];
        state_n = last_word ? CKSUM : REQ;
      end
      CKSUM: if (xfer) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output byte is registered from the next state, so it is already stable
  // when valid rises and cannot change until the transfer moves the FSM.
  always_comb begin
    byte_n = 8'h00;
    case (state_n)
      SYNC:    byte_n = SYNC_BYTE;
      SEQ:     byte_n = seq;
      HI:      byte_n = word_n[15:8];
      LO:      byte_n = word_n[7:0];
      CKSUM:   byte_n = cks_n;
      default: byte_n = 8'h00;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state          <= IDLE;
      seq            <= '0;
      checksum       <= '0;
      word           <= '0;
      idx            <= '0;
      sat_count      <= '0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
    end else begin
      state          <= state_n;
      checksum       <= cks_n;
      word           <= word_n;
      bus.byte_out   <= byte_n;
      bus.byte_valid <= state_n inside {SYNC, SEQ, HI, LO, CKSUM};
      if (state == WAIT && bus.fifo_q == SAT_WORD && sat_count != 8'hFF)
        sat_count <= sat_count + 8'd1;
      if (state == LO && xfer)
        idx <= idx + 8'd1;
      if (state == CKSUM && xfer) begin
        seq <= seq + 8'd1;
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_period_frame_reader.sv
// Directed bench for period_frame_reader with a FIFO model and byte scoreboard.
module tb_period_frame_reader;
  import period_link_pkg::*;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_busy;
  logic [7:0] sat_count;

  period_frame_reader_if ifc ();

  period_frame_reader #(.WORDS_PER_FRAME(W)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .bus        (ifc.master),
    .frame_busy (frame_busy),
    .sat_count  (sat_count)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_seq = 8'h00;
  int          rd_cnt = 0;
  int          xfer_cnt = 0;

  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_i = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // FIFO model: normal mode, data one cycle after rdreq; empty updated after pushes.
  always @(posedge clk) begin
    if (ifc.fifo_rdreq === 1'b1 && mem.size() > 0) ifc.fifo_q <= mem.pop_front();
    #3 ifc.fifo_empty = (mem.size() == 0);
  end

  // Ready driver: constant 1, or repeating 1-0-0-1 pattern.
  always @(posedge clk) begin
    #1 ifc.byte_ready = bp_en ? bp_pat[3 - (bp_i % 4)] : 1'b1;
    bp_i++;
  end

  // Output monitor: scoreboard compare, hold stability, rdreq legality.
  logic       hold = 1'b0;
  logic [7:0] hold_byte = 8'h00;
  logic       prev_rd = 1'b0;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      hold    = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", ifc.byte_valid, 1'b1);
        chk("hold_byte", ifc.byte_out, hold_byte);
      end
      if (ifc.byte_valid && ifc.byte_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, ifc.byte_out}, 32'hFFFF_FFFF);
        else chk("byte", ifc.byte_out, exp_q.pop_front());
      end
      hold      = ifc.byte_valid && !ifc.byte_ready;
      hold_byte = ifc.byte_out;
      if (ifc.fifo_rdreq) begin
        rd_cnt++;
        chk("rdreq_when_empty", ifc.fifo_empty, 1'b0);
        chk("rdreq_single", prev_rd, 1'b0);
      end
      prev_rd = ifc.fifo_rdreq;
    end
  end

  task automatic exp_frame(input logic [15:0] w0, input logic [15:0] w1);
    logic [7:0] c;
    c = exp_seq + w0[15:8] + w0[7:0] + w1[15:8] + w1[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    exp_q.push_back(w0[15:8]); exp_q.push_back(w0[7:0]);
    exp_q.push_back(w1[15:8]); exp_q.push_back(w1[7:0]);
    exp_q.push_back(c);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic push_word(input logic [15:0] w);
    @(posedge clk);
    #2 mem.push_back(w);
  endtask

  // Wait for the scoreboard to drain; busy must be high during the checksum
  // byte's cycle and low on the next one.
  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
    chk("busy_at_cksum", frame_busy, 1'b1);
    @(negedge clk); #1;
    chk("busy_after_cksum", frame_busy, 1'b0);
  endtask

  initial begin
    int rd0, x0, n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdreq", ifc.fifo_rdreq, 1'b0);
    chk("rst_valid", ifc.byte_valid, 1'b0);
    chk("rst_byte", ifc.byte_out, 8'h00);
    chk("rst_busy", frame_busy, 1'b0);
    chk("rst_sat", sat_count, 8'h00);
    @(negedge clk); reset = 1'b0;

    // Basic frame
    rd0 = rd_cnt; x0 = xfer_cnt;
    exp_frame(16'h1234, 16'h00FF);
    push_word(16'h1234); push_word(16'h00FF);
    wait_done(200);
    chk("basic_rdreq_pulses", rd_cnt - rd0, 2);
    chk("basic_frame_len", xfer_cnt - x0, frame_len(W));

    // Backpressure
    bp_en = 1'b1;
    exp_frame(16'h1234, 16'h00FF);
    push_word(16'h1234); push_word(16'h00FF);
    wait_done(400);
    bp_en = 1'b0;

    // Mid-frame underflow
    exp_frame(16'hABCD, 16'h0001);
    push_word(16'hABCD);
    repeat (30) @(negedge clk);
    #1;
    chk("stall_valid", ifc.byte_valid, 1'b0);
    chk("stall_rdreq", ifc.fifo_rdreq, 1'b0);
    chk("stall_busy", frame_busy, 1'b1);
    chk("stall_remaining", exp_q.size(), 3);
    push_word(16'h0001);
    wait_done(200);

    // Reset during the HI byte
    exp_frame(16'h7788, 16'h1122);
    push_word(16'h7788); push_word(16'h1122);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(ifc.byte_valid && ifc.byte_out == 8'h77) && n < 200);
    chk("hi_byte_seen", 32'(n < 200), 32'd1);
    #1;
    exp_q.delete();
    mem.delete();
    reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst_valid", ifc.byte_valid, 1'b0);
    chk("midrst_busy", frame_busy, 1'b0);
    chk("midrst_byte", ifc.byte_out, 8'h00);
    reset = 1'b0;
    exp_seq = 8'h00;
    exp_frame(16'h0102, 16'h0304);
    push_word(16'h0102); push_word(16'h0304);
    wait_done(200);

    // Saturation and seq wrap
    exp_frame(SAT_WORD, SAT_WORD);
    push_word(SAT_WORD); push_word(SAT_WORD);
    wait_done(200);
    chk("sat_two", sat_count, 8'd2);
    for (int f = 0; f < 255; f++) begin
      exp_frame(SAT_WORD, SAT_WORD);
      push_word(SAT_WORD); push_word(SAT_WORD);
    end
    wait_done(20000);
    chk("sat_hold", sat_count, 8'd255);
    chk("seq_model_wrapped", exp_seq, 8'h01);
    exp_frame(16'h0000, 16'h0010);
    push_word(16'h0000); push_word(16'h0010);
    wait_done(200);

    // Empty FIFO idle
    rd0 = rd_cnt;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      chk("idle_quiet", {ifc.fifo_rdreq, ifc.byte_valid, frame_busy}, 3'b000);
    end
    chk("idle_no_pops", rd_cnt - rd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
